// File: rtl/sync_pkg.sv
// sync_pkg: constants and helpers shared by the input-conditioning blocks.
//   SYNC_STAGES_DEF    : default synchroniser depth.
//   SYNC_DB_CYCLES_DEF : default debounce qualification length.
//   sync_cnt_w()       : debounce counter width, clog2 with a floor of 1.
package sync_pkg;

  localparam int SYNC_STAGES_DEF    = 2;
  localparam int SYNC_DB_CYCLES_DEF = 4;

  // The counter only has to reach n-1, so clog2(n) bits are enough.
  // n of 1 or 2 still gets one bit so the counter has a real width.
  function automatic int sync_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_db_chan.sv
// sync_db_chan: one channel of the input conditioner.
//   STAGES-deep synchroniser, optional debounce counter, and registered
//   single-cycle rise/fall pulses.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (wins over en)
//   en   : clock enable; rise/fall are forced low while en is low
//   d    : raw asynchronous input bit
//   q    : synchronised (and debounced) level
//   rise : one-cycle pulse on q 0->1
//   fall : one-cycle pulse on q 1->0
// Macro SYNC_DEBOUNCE_EN: when defined, q only follows the synchronised input
//   once it has differed from q for DB_CYCLES enabled edges in a row; when
//   undefined, q follows the synchroniser output directly.
module sync_db_chan
  import sync_pkg::*;
#(
  parameter int   STAGES    = SYNC_STAGES_DEF,
  parameter int   DB_CYCLES = SYNC_DB_CYCLES_DEF,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_db_chan: STAGES must be >= 2");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("sync_db_chan: DB_CYCLES must be >= 1");
  end

  logic [STAGES-1:0] r_chain;
  logic              r_q;
  logic              r_rise;
  logic              r_fall;
  logic              w_s;

  assign w_s = r_chain[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst)     r_chain <= {STAGES{RST_VAL}};
    else if (en) r_chain <= {r_chain[STAGES-2:0], d};
  end

`ifdef SYNC_DEBOUNCE_EN
  localparam int             CW      = sync_cnt_w(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_q    <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      // Pulses are single-cycle by default; only a qualified change sets one.
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (en) begin
        if (w_s == r_q) begin
          // Any bounce back to the current level restarts qualification.
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_q    <= w_s;
          r_cnt  <= '0;
          r_rise <= w_s;
          r_fall <= ~w_s;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (en) begin
      r_q    <= w_s;
      r_rise <= w_s & ~r_q;
      r_fall <= ~w_s & r_q;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end
  end
`endif

  assign q    = r_q;
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: WIDTH-channel input conditioner for asynchronous board
//   inputs. Each bit is handled by an independent sync_db_chan.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset, priority over en
//   en   : clock enable for all state
//   d    : [WIDTH] raw asynchronous inputs
//   q    : [WIDTH] synchronised, debounced levels (registered)
//   rise : [WIDTH] one-cycle pulses on q 0->1 (registered)
//   fall : [WIDTH] one-cycle pulses on q 1->0 (registered)
// Macro SYNC_DEBOUNCE_EN: defined builds the per-channel debounce counters
//   (latency STAGES+DB_CYCLES); undefined gives a plain synchroniser with
//   edge pulses (latency STAGES+1) and DB_CYCLES is ignored.
module sync_debounce
  import sync_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               STAGES    = SYNC_STAGES_DEF,
  parameter int               DB_CYCLES = SYNC_DB_CYCLES_DEF,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_db_chan #(
      .STAGES    (STAGES),
      .DB_CYCLES (DB_CYCLES),
      .RST_VAL   (RST_VAL[i])
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .d    (d[i]),
      .q    (q[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule
